// File: rtl/uart_rx_fifo_ctrl.sv
// UART receive controller: captures completed characters (or breaks) from the
// receiver, acknowledges them with a one-cycle request pulse, buffers them in a
// FIFO and raises an interrupt on fill level, idle timeout or FIFO overrun.
module uart_rx_fifo_ctrl #(
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned TIMEOUT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  // receiver side
  input  logic [8:0]                 rxDataOut,
  input  logic                       rxDataReceived,
  input  logic                       rxParityError,
  input  logic                       rxOverflow,
  input  logic                       rxBreak,
  output logic                       rxReceiveReq,
  // host read port
  output logic [11:0]                rdData,
  output logic                       rdValid,
  input  logic                       rdReady,
  input  logic                       flush,
  // interrupt control / status
  input  logic [$clog2(DEPTH):0]     threshold,
  input  logic [TIMEOUT_WIDTH-1:0]   timeoutCycles,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       fifoOverrun,
  output logic                       timeout,
  input  logic                       clearOverrun,
  output logic                       irq
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  // ---------------------------------------------------------------------------
  // Capture / acknowledge sequencer
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    StIdle,
    StAck,
    StWait
  } state_e;

  state_e      state_q, state_d;
  logic        push_req;
  logic [11:0] push_data;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, capture request and acknowledge pulse
  always_comb begin
    state_d      = state_q;
    push_req     = 1'b0;
    push_data    = '0;
    rxReceiveReq = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A character wins over a simultaneous break; one ack clears both.
        if (rxDataReceived) begin
          push_req  = 1'b1;
          push_data = {rxOverflow, 1'b0, rxParityError, rxDataOut};
          state_d   = StAck;
        end else if (rxBreak) begin
          push_req  = 1'b1;
          push_data = {rxOverflow, 1'b1, 1'b0, 9'h000};
          state_d   = StAck;
        end
      end
      StAck: begin
        rxReceiveReq = 1'b1;
        state_d      = StWait;
      end
      StWait: begin
        // Receiver needs time to drop its levels after the acknowledge.
        if (!rxDataReceived && !rxBreak) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic [11:0]   mem_q [DEPTH];
  logic          pop;
  logic          full;
  logic          push_ok;
  logic          push_drop;

  assign rdValid   = (count_q != '0);
  assign pop       = rdValid && rdReady;
  assign full      = (count_q == CW'(DEPTH));
  // A pop in the same cycle frees the slot a full FIFO would otherwise lack.
  assign push_ok   = push_req && !flush && (!full || pop);
  assign push_drop = push_req && !flush && full && !pop;

  // Pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) begin
        wptr_q <= wptr_q + AW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + AW'(1);
      end
      if (push_ok && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (!push_ok && pop) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  // Storage; no reset needed since the read port is gated by rdValid
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wptr_q] <= push_data;
    end
  end

  assign rdData = rdValid ? mem_q[rptr_q] : 12'h000;
  assign count  = count_q;

  // ---------------------------------------------------------------------------
  // Idle timeout
  // ---------------------------------------------------------------------------
  logic [TIMEOUT_WIDTH-1:0] idle_cnt_q, idle_cnt_d;

  // Idle counter next value: restart on activity or empty, else saturate
  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (push_req || pop || flush || !rdValid) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q >= timeoutCycles) begin
      // Clamping (rather than holding) lets a lowered limit re-match at once.
      idle_cnt_d = timeoutCycles;
    end else begin
      idle_cnt_d = idle_cnt_q + TIMEOUT_WIDTH'(1);
    end
  end

  // Idle counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end

  assign timeout = rdValid && (timeoutCycles != '0) && (idle_cnt_q == timeoutCycles);

  // ---------------------------------------------------------------------------
  // Overrun flag and interrupt
  // ---------------------------------------------------------------------------
  logic overrun_q, overrun_d;
  logic thr_hit;
  logic irq_q;

  // Sticky overrun: a set in the same cycle as a clear takes priority
  always_comb begin
    overrun_d = overrun_q;
    if (push_drop) begin
      overrun_d = 1'b1;
    end else if (clearOverrun) begin
      overrun_d = 1'b0;
    end
  end

  assign thr_hit = (threshold != '0) && (count_q >= threshold);

  // Overrun flag and registered interrupt
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
      irq_q     <= thr_hit | timeout | overrun_q;
    end
  end

  assign fifoOverrun = overrun_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Self-checking bench for uart_rx_fifo_ctrl with a queue scoreboard of
// expected FIFO entries.
module tb_uart_rx_fifo_ctrl;

  localparam int DEPTH = 16;
  localparam int TW    = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [8:0]    rxDataOut = '0;
  logic          rxDataReceived = 1'b0;
  logic          rxParityError = 1'b0;
  logic          rxOverflow = 1'b0;
  logic          rxBreak = 1'b0;
  logic          rxReceiveReq;
  logic [11:0]   rdData;
  logic          rdValid;
  logic          rdReady = 1'b0;
  logic          flush = 1'b0;
  logic [CW-1:0] threshold = '0;
  logic [TW-1:0] timeoutCycles = '0;
  logic [CW-1:0] count;
  logic          fifoOverrun;
  logic          timeout;
  logic          clearOverrun = 1'b0;
  logic          irq;

  uart_rx_fifo_ctrl #(
    .DEPTH        (DEPTH),
    .TIMEOUT_WIDTH(TW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rxDataOut     (rxDataOut),
    .rxDataReceived(rxDataReceived),
    .rxParityError (rxParityError),
    .rxOverflow    (rxOverflow),
    .rxBreak       (rxBreak),
    .rxReceiveReq  (rxReceiveReq),
    .rdData        (rdData),
    .rdValid       (rdValid),
    .rdReady       (rdReady),
    .flush         (flush),
    .threshold     (threshold),
    .timeoutCycles (timeoutCycles),
    .count         (count),
    .fifoOverrun   (fifoOverrun),
    .timeout       (timeout),
    .clearOverrun  (clearOverrun),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [11:0] exp_q[$];
  int          mcount = 0;

  // Snapshots taken by send_char at the acknowledge cycle and the one after.
  logic [CW-1:0] req_cnt;
  logic          req_irq, req_valid, req_ovr, irq_after;
  int            req_cyc;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got running, expected finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    rxDataReceived = 1'b0;
    rxBreak = 1'b0;
    rdReady = 1'b0;
    flush = 1'b0;
    clearOverrun = 1'b0;
    threshold = '0;
    timeoutCycles = '0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    exp_q.delete();
    mcount = 0;
  endtask

  // Acts as the receiver: raise ready (or break), wait for the ack pulse,
  // keep the level for `hold` more cycles, then drop it.
  task automatic send_char(input logic [8:0] d, input logic pe, input logic ov,
                           input logic brk, input logic do_pop, input logic clr,
                           input int hold);
    logic [11:0] exp_e;
    logic [11:0] head;
    logic        got;
    exp_e = brk ? {ov, 1'b1, 1'b0, 9'h000} : {ov, 1'b0, pe, d};
    if (do_pop) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pop_head: scoreboard empty, rdValid=%b", rdValid);
      end else begin
        head = exp_q.pop_front();
        mcount--;
        if (rdValid !== 1'b1 || rdData !== head) begin
          n_fail++;
          $display("FAIL pop_head: got valid=%b data=%h, expected valid=1 data=%h",
                   rdValid, rdData, head);
        end
      end
      rdReady = 1'b1;
    end
    if (mcount < DEPTH) begin
      exp_q.push_back(exp_e);
      mcount++;
    end
    rxDataOut     = d;
    rxParityError = pe;
    rxOverflow    = ov;
    clearOverrun  = clr;
    if (brk) rxBreak = 1'b1;
    else rxDataReceived = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      rdReady      = 1'b0;
      clearOverrun = 1'b0;
      if (rxReceiveReq === 1'b1) got = 1'b1;
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL req_wait: got no rxReceiveReq in 20 cycles, expected one pulse");
    end
    req_cnt   = count;
    req_irq   = irq;
    req_valid = rdValid;
    req_ovr   = fifoOverrun;
    req_cyc   = cyc;
    tick();
    irq_after = irq;
    n_checks++;
    if (rxReceiveReq !== 1'b0) begin
      n_fail++;
      $display("FAIL req_pulse: got rxReceiveReq=%b on 2nd cycle, expected 0", rxReceiveReq);
    end
    for (int i = 0; i < hold; i++) begin
      tick();
      n_checks++;
      if (rxReceiveReq !== 1'b0) begin
        n_fail++;
        $display("FAIL extra_req: got rxReceiveReq=%b while level held, expected 0",
                 rxReceiveReq);
      end
    end
    rxDataReceived = 1'b0;
    rxBreak        = 1'b0;
    tick();
  endtask

  task automatic pop_check(input string name);
    logic [11:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, got valid=%b data=%h", name, rdValid, rdData);
    end else begin
      e = exp_q.pop_front();
      mcount--;
      if (rdValid !== 1'b1 || rdData !== e) begin
        n_fail++;
        $display("FAIL %s: got valid=%b data=%h, expected valid=1 data=%h",
                 name, rdValid, rdData, e);
      end
    end
    rdReady = 1'b1;
    tick();
    rdReady = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    n_checks++;
    if ({rxReceiveReq, rdValid, fifoOverrun, timeout, irq} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got req/valid/ovr/to/irq=%b, expected 00000",
               {rxReceiveReq, rdValid, fifoOverrun, timeout, irq});
    end
    n_checks++;
    if (count !== '0 || rdData !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_fifo: got count=%0d data=%h, expected 0 and 000", count, rdData);
    end
    do_reset();
  endtask

  task automatic test_single();
    send_char(9'h0A5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    n_checks++;
    if (req_valid !== 1'b1 || req_cnt !== CW'(1)) begin
      n_fail++;
      $display("FAIL single_latency: at ack got valid=%b count=%0d, expected 1 and 1",
               req_valid, req_cnt);
    end
    n_checks++;
    if (rdData !== 12'h2A5) begin
      n_fail++;
      $display("FAIL single_data: got %h, expected 2a5", rdData);
    end
    pop_check("single_pop");
    n_checks++;
    if (count !== '0 || rdValid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_empty: got count=%0d valid=%b, expected 0 and 0", count, rdValid);
    end
  endtask

  task automatic test_break();
    send_char(9'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5);
    tick();
    n_checks++;
    if (count !== CW'(1) || rdData !== 12'h400) begin
      n_fail++;
      $display("FAIL break_entry: got count=%0d data=%h, expected 1 and 400", count, rdData);
    end
    pop_check("break_pop");
  endtask

  task automatic test_fill();
    threshold = CW'(8);
    for (int i = 1; i <= 17; i++) begin
      send_char(9'(i * 7 + 3), 1'(i % 3 == 0), 1'(i == 5), 1'b0, 1'b0, 1'b0, 1);
      if (i == 7) begin
        n_checks++;
        if (irq_after !== 1'b0) begin
          n_fail++;
          $display("FAIL fill_irq_early: got irq=%b at count 7, expected 0", irq_after);
        end
      end
      if (i == 8) begin
        n_checks++;
        if (req_cnt !== CW'(8) || req_irq !== 1'b0 || irq_after !== 1'b1) begin
          n_fail++;
          $display("FAIL fill_irq_edge: got count=%0d irq=%b then %b, expected 8, 0, 1",
                   req_cnt, req_irq, irq_after);
        end
      end
      if (i == 17) begin
        n_checks++;
        if (req_cnt !== CW'(16) || req_ovr !== 1'b1) begin
          n_fail++;
          $display("FAIL fill_overrun: got count=%0d ovr=%b, expected 16 and 1",
                   req_cnt, req_ovr);
        end
      end
    end
    clearOverrun = 1'b1;
    tick();
    clearOverrun = 1'b0;
    tick();
    n_checks++;
    if (fifoOverrun !== 1'b0 || irq !== 1'b1 || count !== CW'(16)) begin
      n_fail++;
      $display("FAIL fill_clear: got ovr=%b irq=%b count=%0d, expected 0, 1, 16",
               fifoOverrun, irq, count);
    end
    for (int i = 0; i < 16; i++) pop_check("fill_order");
    tick();
    n_checks++;
    if (count !== '0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_drained: got count=%0d irq=%b, expected 0 and 0", count, irq);
    end
    threshold = '0;
  endtask

  task automatic test_timeout();
    int start;
    logic seen;
    timeoutCycles = TW'(100);
    send_char(9'h155, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    start = req_cyc;
    seen  = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      if (timeout === 1'b1) seen = 1'b1;
      else tick();
    end
    n_checks++;
    if (!seen || (cyc - start) != 100) begin
      n_fail++;
      $display("FAIL timeout_delay: got seen=%b after %0d cycles, expected 1 after 100",
               seen, cyc - start);
    end
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_irq_early: got irq=%b with timeout, expected 0", irq);
    end
    tick();
    n_checks++;
    if (irq !== 1'b1 || timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_irq: got irq=%b timeout=%b, expected 1 and 1", irq, timeout);
    end
    pop_check("timeout_pop");
    n_checks++;
    if (timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_clear: got timeout=%b after pop, expected 0", timeout);
    end
    tick();
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_irq_clear: got irq=%b, expected 0", irq);
    end
    timeoutCycles = '0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) begin
      send_char(9'(i + 32), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    end
    for (int i = 0; i < 40; i++) begin
      send_char(9'(i * 11 + 100), 1'(i % 2), 1'b0, 1'b0, 1'b1, 1'b0, 1);
      n_checks++;
      if (req_cnt !== CW'(16) || req_ovr !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_full: iter %0d got count=%0d ovr=%b, expected 16 and 0",
                 i, req_cnt, req_ovr);
      end
    end
    // Overrun set and clearOverrun coincide: the set must win.
    send_char(9'h1FF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    n_checks++;
    if (req_ovr !== 1'b1 || req_cnt !== CW'(16)) begin
      n_fail++;
      $display("FAIL set_wins: got ovr=%b count=%0d, expected 1 and 16", req_ovr, req_cnt);
    end
    for (int i = 0; i < 8; i++) pop_check("b2b_order");
    flush = 1'b1;
    tick();
    flush = 1'b0;
    exp_q.delete();
    mcount = 0;
    n_checks++;
    if (count !== '0 || rdValid !== 1'b0 || fifoOverrun !== 1'b1) begin
      n_fail++;
      $display("FAIL flush: got count=%0d valid=%b ovr=%b, expected 0, 0, 1",
               count, rdValid, fifoOverrun);
    end
    clearOverrun = 1'b1;
    tick();
    clearOverrun = 1'b0;
    n_checks++;
    if (fifoOverrun !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_clear: got ovr=%b, expected 0", fifoOverrun);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    threshold = CW'(4);
    for (int i = 0; i < 5; i++) send_char(9'(i + 1), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    rxDataOut      = 9'h1C3;
    rxParityError  = 1'b0;
    rxOverflow     = 1'b0;
    rxDataReceived = 1'b1;
    tick();
    n_checks++;
    if (rxReceiveReq !== 1'b1 || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pre: got req=%b irq=%b before reset, expected 1 and 1",
               rxReceiveReq, irq);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if ({rxReceiveReq, rdValid, fifoOverrun, timeout, irq} !== 5'b0 ||
        count !== '0 || rdData !== 12'h000) begin
      n_fail++;
      $display("FAIL mid_async: got req/valid/ovr/to/irq=%b count=%0d data=%h, expected 0s",
               {rxReceiveReq, rdValid, fifoOverrun, timeout, irq}, count, rdData);
    end
    #2;
    rst = 1'b1;
    exp_q.delete();
    exp_q.push_back(12'h1C3);
    mcount = 1;
    tick();
    n_checks++;
    if (rxReceiveReq !== 1'b1 || count !== CW'(1) || rdData !== 12'h1C3) begin
      n_fail++;
      $display("FAIL mid_recapture: got req=%b count=%0d data=%h, expected 1, 1, 1c3",
               rxReceiveReq, count, rdData);
    end
    tick();
    tick();
    rxDataReceived = 1'b0;
    tick();
    pop_check("mid_pop");
    threshold = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_break();
    test_fill();
    test_timeout();
    do_reset();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
